alu_sub_pipe: RTL and testbench
===============================

Name: alu_sub_pipe

Overview:
Parametrised, pipelined multi-lane add/subtract test block behind the standard 128-bit FPGA test IO harness (IN/OUT/clk). It is the successor to the single-lane 16-bit subtract test. New relative to that test: configurable width, lane count and pipeline depth; four operations; carry/borrow and zero flags; a valid-result counter; and a configurable-length delay-line probe. It is used as a fabric-to-silicon regression design for CLB arithmetic and flop chains.

Parameters:
WIDTH, 16, operand/result width per lane; LANES*WIDTH <= 60 is required.
LANES, 2, number of independent ALU lanes (1..4).
STAGES, 2, input-to-output latency in clk cycles (1..4).
DELAY, 2, length of the IN[0] delay-line probe (1..8).

Ports:
clk  input  1  harness clock; all state is on its rising edge.
rst_n  input  1  reset, asynchronous, active-low.
IN  input  128  harness input bus; field map below.
OUT  output  128  harness output bus, fully registered; field map below.

Behaviour:
- IN map:
  - Lane k: A_k = IN[k*2*WIDTH +: WIDTH], B_k = IN[k*2*WIDTH+WIDTH +: WIDTH].
  - IN[121:120] op, IN[122] in_valid, IN[123] clr_count, IN[0] also feeds the delay line.
  - All other bits are ignored.
- op encoding:
  - 00 SUB: A-B, wrap modulo 2^WIDTH; flag = borrow (A<B).
  - 01 ADD: A+B, wrap; flag = carry-out.
  - 10 SUBS: A-B, unsigned saturating; result 0 when A<B; flag = borrow (A<B).
  - 11 RSUB: B-A, wrap; flag = borrow (B<A).
  - zero flag = (final result == 0), evaluated after saturation.
- OUT map:
  - OUT[k*WIDTH +: WIDTH] result of lane k.
  - OUT[64+k] carry/borrow flag of lane k; OUT[80+k] zero flag of lane k.
  - OUT[111:96] 16-bit valid-result counter.
  - OUT[112+i] delay-line tap i, for i < DELAY.
  - OUT[127] out_valid.
  - All unused bits are constant 0.
- Pipeline:
  - Lane results are computed from IN in the sampling cycle and carried with op-independent flags and valid through STAGES registers.
  - in_valid sampled at edge t appears as out_valid=1 after edge t+STAGES-1 (visible STAGES cycles later).
  - Accepts one op every cycle; no backpressure.
- Bubbles: if the last stage is invalid, out_valid=0 and result/flag fields hold their last valid values.
- Counter:
  - Increments on each cycle the last stage is valid; wraps 0xFFFF -> 0x0000.
  - clr_count is sampled at the same edge as in_valid and acts on the counter directly (no pipeline delay).
  - clr_count and an increment in the same cycle: clear wins, counter = 0.
- Delay line:
  - tap0 <= IN[0]; tap i <= tap i-1 every cycle, independent of in_valid.
  - Generalises the two-flop R0 chain.
- Reset:
  - rst_n low immediately clears all pipeline stages, valids, OUT (all 128 bits), counter and delay line.
  - In-flight operations are dropped.
  - First valid output after release requires a fresh in_valid.

Decomposition:
- Package alu_sub_pkg holds:
  - op encodings (OP_SUB, OP_ADD, OP_SUBS, OP_RSUB)
  - IN/OUT field offsets (OP_LSB=120, VALID_BIT=122, CLR_BIT=123, FLAG_LSB=64, ZERO_LSB=80, CNT_LSB=96, TAP_LSB=112, OVALID_BIT=127)
  - elaboration-time parameter legality checks
- Sub-module alu_sub_lane: one combinational lane (WIDTH-parametrised; A, B, op in; result, flag, zero out), instantiated LANES times.
- The top holds the pipeline, counter and delay line.

Test Plan:
All scenarios use the defaults WIDTH=16, LANES=2, STAGES=2, DELAY=2.
1. Reset: rst_n=0 with IN=all ones -> OUT==0 asynchronously; after release with in_valid=0, OUT[127]=0 and OUT[111:96]=0.
2. SUB, lane0 A=0x0005 B=0x0003, lane1 A=0x0003 B=0x0005, in_valid=1 at edge t -> after edge t+1:
   - OUT[15:0]=0x0002, OUT[31:16]=0xFFFE
   - OUT[64]=0, OUT[65]=1, OUT[127]=1, counter=1.
3. SUBS, lane0 A=0x0003 B=0x0005 -> result 0x0000, borrow 1, zero 1. RSUB, A=0x0002 B=0x0007 -> 0x0005, flag 0.
4. ADD, A=0xFFFF B=0x0001 -> 0x0000, carry 1, zero 1. ADD, A=0x1234 B=0x0001 -> 0x1235, carry 0, zero 0.
5. Stream and counter clear:
   - Three back-to-back valids then a bubble -> out_valid 1,1,1,0; results hold the third value during the bubble; counter=3.
   - clr_count=1 together with in_valid=1 -> counter 0 at that edge.
   - The result of that clearing-cycle op increments the counter to 1 at its own output edge.
6. Delay line and mid-operation reset:
   - One-cycle IN[0] pulse -> OUT[112] high for exactly one cycle, then OUT[113] for the following cycle.
   - rst_n pulsed low while two ops are in flight -> OUT=0 immediately and no out_valid afterwards without new input.

Source files
------------

// File: rtl/alu_sub_pkg.sv
// Shared definitions for the alu_sub_pipe harness test block: op codes,
// harness bus field offsets and the parameter legality check.
package alu_sub_pkg;

  typedef enum logic [1:0] {
    OP_SUB  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUBS = 2'b10,
    OP_RSUB = 2'b11
  } op_e;

  localparam int BUS_W      = 128;
  localparam int CNT_W      = 16;
  localparam int OP_LSB     = 120;
  localparam int VALID_BIT  = 122;
  localparam int CLR_BIT    = 123;
  localparam int FLAG_LSB   = 64;
  localparam int ZERO_LSB   = 80;
  localparam int CNT_LSB    = 96;
  localparam int TAP_LSB    = 112;
  localparam int OVALID_BIT = 127;

  // Lanes must fit below the flag field on OUT; flags, taps and depth have fixed slots.
  function automatic bit params_ok(input int width, input int lanes,
                                   input int stages, input int delay);
    return (width >= 1) && (lanes >= 1) && (lanes <= 4) && (lanes * width <= 60) &&
           (stages >= 1) && (stages <= 4) && (delay >= 1) && (delay <= 8);
  endfunction

endpackage

// File: rtl/alu_sub_pipe_if.sv
// Harness bus bundle: 128-bit IN driven by the harness, 128-bit OUT from the block.
interface alu_sub_pipe_if;
  import alu_sub_pkg::*;

  logic [BUS_W-1:0] IN;
  logic [BUS_W-1:0] OUT;

  modport master (output IN, input OUT);
  modport slave  (input IN, output OUT);
endinterface

// File: rtl/alu_sub_lane.sv
// One combinational add/subtract lane with carry/borrow and zero flags.
module alu_sub_lane
  import alu_sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             flag_o,
  output logic             zero_o
);

  // One extra bit on each result carries the carry-out or borrow.
  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] dab_s;
  logic [WIDTH:0] dba_s;

  assign sum_s = {1'b0, a_i} + {1'b0, b_i};
  assign dab_s = {1'b0, a_i} - {1'b0, b_i};
  assign dba_s = {1'b0, b_i} - {1'b0, a_i};

  // Select the operation result and flag; zero is judged on the final (saturated) result.
  always_comb begin
    res_o  = '0;
    flag_o = 1'b0;
    case (op_i)
      OP_SUB: begin
        res_o  = dab_s[WIDTH-1:0];
        flag_o = dab_s[WIDTH];
      end
      OP_ADD: begin
        res_o  = sum_s[WIDTH-1:0];
        flag_o = sum_s[WIDTH];
      end
      OP_SUBS: begin
        flag_o = dab_s[WIDTH];
        if (dab_s[WIDTH]) begin
          res_o = '0;
        end else begin
          res_o = dab_s[WIDTH-1:0];
        end
      end
      OP_RSUB: begin
        res_o  = dba_s[WIDTH-1:0];
        flag_o = dba_s[WIDTH];
      end
      default: begin
        res_o  = '0;
        flag_o = 1'b0;
      end
    endcase
    zero_o = (res_o == '0);
  end

endmodule

// File: rtl/alu_sub_pipe.sv
// Pipelined multi-lane add/subtract block behind the 128-bit harness bus,
// with a valid-result counter and an IN[0] delay-line probe.
module alu_sub_pipe
  import alu_sub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANES  = 2,
  parameter int STAGES = 2,
  parameter int DELAY  = 2
) (
  input logic           clk,
  input logic           rst_n,
  alu_sub_pipe_if.slave bus
);

  localparam int LW = LANES * WIDTH;

  if (!params_ok(WIDTH, LANES, STAGES, DELAY)) begin : g_param_check
    $error("alu_sub_pipe: illegal WIDTH/LANES/STAGES/DELAY combination");
  end

  logic [LW-1:0]    lane_res_s;
  logic [LANES-1:0] lane_flag_s;
  logic [LANES-1:0] lane_zero_s;
  op_e              op_s;
  logic             in_valid_s;
  logic             clr_s;
  logic             unused_in_s;

  assign op_s        = op_e'(bus.IN[OP_LSB +: 2]);
  assign in_valid_s  = bus.IN[VALID_BIT];
  assign clr_s       = bus.IN[CLR_BIT];
  assign unused_in_s = ^bus.IN;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    alu_sub_lane #(.WIDTH(WIDTH)) u_lane (
      .a_i   (bus.IN[k*2*WIDTH +: WIDTH]),
      .b_i   (bus.IN[k*2*WIDTH+WIDTH +: WIDTH]),
      .op_i  (op_s),
      .res_o (lane_res_s[k*WIDTH +: WIDTH]),
      .flag_o(lane_flag_s[k]),
      .zero_o(lane_zero_s[k])
    );
  end

  logic [LW-1:0]    res_q  [STAGES];
  logic [LW-1:0]    res_d  [STAGES];
  logic [LANES-1:0] flag_q [STAGES];
  logic [LANES-1:0] flag_d [STAGES];
  logic [LANES-1:0] zero_q [STAGES];
  logic [LANES-1:0] zero_d [STAGES];
  logic [STAGES-1:0] v_q, v_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DELAY-1:0]  tap_q, tap_d;
  logic [BUS_W-1:0]  out_s;

  // Advance the pipeline; a stage only reloads data when valid arrives, so bubbles hold old values.
  always_comb begin
    res_d  = res_q;
    flag_d = flag_q;
    zero_d = zero_q;
    v_d    = '0;
    v_d[0] = in_valid_s;
    if (in_valid_s) begin
      res_d[0]  = lane_res_s;
      flag_d[0] = lane_flag_s;
      zero_d[0] = lane_zero_s;
    end else begin
      res_d[0]  = res_q[0];
      flag_d[0] = flag_q[0];
      zero_d[0] = zero_q[0];
    end
    for (int s = 1; s < STAGES; s++) begin
      v_d[s] = v_q[s-1];
      if (v_q[s-1]) begin
        res_d[s]  = res_q[s-1];
        flag_d[s] = flag_q[s-1];
        zero_d[s] = zero_q[s-1];
      end else begin
        res_d[s]  = res_q[s];
        flag_d[s] = flag_q[s];
        zero_d[s] = zero_q[s];
      end
    end
  end

  // Count results as they land in the last stage; a clear in the same cycle wins.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_s) begin
      cnt_d = '0;
    end else if (v_d[STAGES-1]) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Free-running IN[0] shift chain, independent of in_valid.
  always_comb begin
    tap_d    = '0;
    tap_d[0] = bus.IN[0];
    for (int i = 1; i < DELAY; i++) begin
      tap_d[i] = tap_q[i-1];
    end
  end

  // State registers; reset drops in-flight work and clears every OUT source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        res_q[s]  <= '0;
        flag_q[s] <= '0;
        zero_q[s] <= '0;
      end
      v_q   <= '0;
      cnt_q <= '0;
      tap_q <= '0;
    end else begin
      res_q  <= res_d;
      flag_q <= flag_d;
      zero_q <= zero_d;
      v_q    <= v_d;
      cnt_q  <= cnt_d;
      tap_q  <= tap_d;
    end
  end

  // Pack registered state onto OUT; every unused bit stays 0.
  always_comb begin
    out_s                      = '0;
    out_s[LW-1:0]              = res_q[STAGES-1];
    out_s[FLAG_LSB +: LANES]   = flag_q[STAGES-1];
    out_s[ZERO_LSB +: LANES]   = zero_q[STAGES-1];
    out_s[CNT_LSB +: CNT_W]    = cnt_q;
    out_s[TAP_LSB +: DELAY]    = tap_q;
    out_s[OVALID_BIT]          = v_q[STAGES-1];
  end

  assign bus.OUT = out_s;

endmodule

// File: tb/tb_alu_sub_pipe.sv
// Scoreboard bench for alu_sub_pipe at the default parameters.
module tb_alu_sub_pipe;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  flag;
    logic [1:0]  zero;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_sub_pipe_if bus_if ();

  alu_sub_pipe #(.WIDTH(16), .LANES(2), .STAGES(2), .DELAY(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  logic [31:0] last_res;
  logic [1:0]  last_flag;
  logic [1:0]  last_zero;
  logic [15:0] exp_cnt;
  logic [1:0]  hist;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    last_res  = '0;
    last_flag = '0;
    last_zero = '0;
    exp_cnt   = '0;
    hist      = '0;
  endtask

  // Reference: each op evaluated with plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [15:0] a0, input logic [15:0] b0,
                                 input logic [15:0] a1, input logic [15:0] b1, input int due);
    exp_t e;
    int a[2];
    int b[2];
    int r;
    bit f;
    a[0] = a0; b[0] = b0; a[1] = a1; b[1] = b1;
    e.due = due;
    for (int k = 0; k < 2; k++) begin
      case (op)
        2'd0:    begin r = (a[k] - b[k] + 65536) % 65536; f = a[k] < b[k]; end
        2'd1:    begin r = (a[k] + b[k]) % 65536; f = (a[k] + b[k]) > 65535; end
        2'd2:    begin r = (a[k] < b[k]) ? 0 : a[k] - b[k]; f = a[k] < b[k]; end
        default: begin r = (b[k] - a[k] + 65536) % 65536; f = b[k] < a[k]; end
      endcase
      e.res[16*k +: 16] = r[15:0];
      e.flag[k] = f;
      e.zero[k] = (r == 0);
    end
    return e;
  endfunction

  // Drive one cycle of IN at the falling edge; ignored bits get random junk.
  task automatic issue(input bit v, input bit clr, input logic [1:0] op,
                       input logic [15:0] a0, input logic [15:0] b0,
                       input logic [15:0] a1, input logic [15:0] b1);
    logic [127:0] w;
    @(negedge clk);
    w = {$urandom, $urandom, $urandom, $urandom};
    w[15:0]    = a0;
    w[31:16]   = b0;
    w[47:32]   = a1;
    w[63:48]   = b1;
    w[121:120] = op;
    w[122]     = v;
    w[123]     = clr;
    bus_if.IN  = w;
    if (v) exp_q.push_back(model(op, a0, b0, a1, b1, edge_n + 2));
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
  endtask

  // Monitor: after every edge, rebuild the whole expected OUT word and compare.
  initial begin : monitor
    logic         clr_e;
    logic         in0_e;
    logic         exp_v;
    logic [127:0] exp_out;
    exp_t         it;
    forever begin
      @(posedge clk);
      clr_e = bus_if.IN[123];
      in0_e = bus_if.IN[0];
      #1;
      if (rst_n !== 1'b1) continue;
      exp_v = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due <= edge_n) begin
        it        = exp_q.pop_front();
        exp_v     = 1'b1;
        last_res  = it.res;
        last_flag = it.flag;
        last_zero = it.zero;
      end
      hist = {hist[0], in0_e};
      if (clr_e) exp_cnt = 16'h0000;
      else if (exp_v) exp_cnt = exp_cnt + 16'h0001;
      exp_out            = '0;
      exp_out[31:0]      = last_res;
      exp_out[65:64]     = last_flag;
      exp_out[81:80]     = last_zero;
      exp_out[111:96]    = exp_cnt;
      exp_out[113:112]   = hist;
      exp_out[127]       = exp_v;
      check("out_word", bus_if.OUT, exp_out);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] ra0, rb0, ra1, rb1;
    flush_model();
    bus_if.IN = '1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_async", bus_if.OUT, 128'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus_if.IN = '0;
    rst_n = 1'b1;
    repeat (2) idle();
    @(posedge clk); #2;
    check("reset_ovalid", {127'h0, bus_if.OUT[127]}, 128'h0);
    check("reset_count", {112'h0, bus_if.OUT[111:96]}, 128'h0);

    // SUB, both borrow polarities.
    issue(1'b1, 1'b0, 2'd0, 16'h0005, 16'h0003, 16'h0003, 16'h0005);
    idle();
    @(posedge clk); #2;
    check("sub_results", {96'h0, bus_if.OUT[31:0]}, {96'h0, 32'hFFFE_0002});
    check("sub_flags", {126'h0, bus_if.OUT[65:64]}, {126'h0, 2'b10});
    check("sub_ovalid", {127'h0, bus_if.OUT[127]}, {127'h0, 1'b1});
    check("sub_count", {112'h0, bus_if.OUT[111:96]}, {112'h0, 16'h0001});

    // SUBS saturation, RSUB, ADD carry and no-carry.
    issue(1'b1, 1'b0, 2'd2, 16'h0003, 16'h0005, 16'h0009, 16'h0002);
    issue(1'b1, 1'b0, 2'd3, 16'h0002, 16'h0007, 16'h0007, 16'h0002);
    issue(1'b1, 1'b0, 2'd1, 16'hFFFF, 16'h0001, 16'h1234, 16'h0001);
    issue(1'b1, 1'b0, 2'd1, 16'h1234, 16'h0001, 16'hFFFF, 16'h0001);
    idle();
    idle();

    // Stream of three then bubbles, clear with valid, clear colliding with an increment.
    issue(1'b1, 1'b0, 2'd0, 16'h0100, 16'h0001, 16'h0200, 16'h0002);
    issue(1'b1, 1'b0, 2'd1, 16'h0100, 16'h0001, 16'h0200, 16'h0002);
    issue(1'b1, 1'b0, 2'd3, 16'h0100, 16'h0001, 16'h0200, 16'h0002);
    idle();
    idle();
    idle();
    issue(1'b1, 1'b1, 2'd0, 16'h0010, 16'h0001, 16'h0020, 16'h0001);
    idle();
    issue(1'b1, 1'b0, 2'd1, 16'h0001, 16'h0001, 16'h0002, 16'h0002);
    issue(1'b0, 1'b1, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    idle();
    idle();

    // Single-cycle IN[0] pulse through the delay line.
    issue(1'b0, 1'b0, 2'd0, 16'h0001, 16'h0000, 16'h0000, 16'h0000);
    idle();
    idle();
    idle();

    // Reset with two ops in flight.
    issue(1'b1, 1'b0, 2'd0, 16'h0009, 16'h0001, 16'h0008, 16'h0001);
    issue(1'b1, 1'b0, 2'd1, 16'h0009, 16'h0001, 16'h0008, 16'h0001);
    @(posedge clk); #2;
    bus_if.IN = '0;
    rst_n = 1'b0;
    flush_model();
    #1 check("reset_midflight", bus_if.OUT, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) idle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      ra0 = 16'($urandom); rb0 = 16'($urandom);
      ra1 = 16'($urandom); rb1 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb0 = ra0;
      if ($urandom_range(0, 3) == 0) rb1 = 16'($urandom_range(0, 3));
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
            2'($urandom_range(0, 3)), ra0, rb0, ra1, rb1);
    end
    repeat (5) idle();
    @(posedge clk); #2;
    check("scoreboard_drained", 128'(exp_q.size()), 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
